// File: rtl/axi_master_generic.sv
// axi_master_generic: AXI3 initiator turning a command/stream interface into
// one INCR burst of 32-bit beats at a time. Completion is a one-cycle
// done_valid pulse carrying the final response code.
// Optional build macro: AXI_MASTER_TIMEOUT_EN adds a response-wait watchdog
// that ends a stalled transaction with SLVERR after TIMEOUT_CYCLES cycles.
module axi_master_generic #(
    parameter int ADDR_W         = 32,
    parameter int MAX_LEN        = 16,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              aclk,
    input  logic              areset,
    // command / stream side
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [3:0]        cmd_len,
    input  logic [3:0]        cmd_id,
    input  logic [31:0]       wr_data,
    input  logic [3:0]        wr_strb,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [31:0]       rd_data,
    output logic              rd_valid,
    output logic              done_valid,
    output logic [1:0]        done_resp,
    // AW channel
    output logic [3:0]        awid,
    output logic [ADDR_W-1:0] awadr,
    output logic [3:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic [1:0]        awlock,
    output logic [3:0]        awcache,
    output logic [2:0]        awprot,
    output logic              awvalid,
    input  logic              awready,
    // W channel
    output logic [3:0]        wid,
    output logic [31:0]       wrdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    // B channel
    input  logic [3:0]        bid,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready,
    // AR channel
    output logic [3:0]        arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [3:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic [1:0]        arlock,
    output logic [3:0]        arcache,
    output logic [2:0]        arprot,
    output logic              arvalid,
    input  logic              arready,
    // R channel
    input  logic [3:0]        rid,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready
);

    localparam int LEN_W = $clog2(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE
    } state_t;

    state_t             state, state_nx;
    logic [ADDR_W-1:0]  addr_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   cnt_q;
    logic [3:0]         id_q;
    logic [1:0]         resp_q;
    logic [1:0]         rd_resp_nx;
    logic               w_hs, r_hs, r_end;

    // IDs are not checked; the timeout limit is only consumed by the watchdog
    logic unused_inputs;
    assign unused_inputs = ^{bid, rid, 32'(TIMEOUT_CYCLES)};

    // Fixed burst attributes: 4-byte beats, INCR, normal/unprivileged access
    assign awsize  = 3'b010;
    assign arsize  = 3'b010;
    assign awburst = 2'b01;
    assign arburst = 2'b01;
    assign awlock  = 2'b00;
    assign arlock  = 2'b00;
    assign awcache = 4'b0000;
    assign arcache = 4'b0000;
    assign awprot  = 3'b000;
    assign arprot  = 3'b000;

    assign awid   = id_q;
    assign arid   = id_q;
    assign wid    = id_q;
    assign awadr  = addr_q;
    assign araddr = addr_q;
    assign awlen  = 4'(len_q);
    assign arlen  = 4'(len_q);
    assign wrdata = wr_data;
    assign wstrb  = wr_strb;
    assign done_resp = resp_q;

    assign w_hs  = wvalid && wready;
    assign r_hs  = rvalid && rready;
    assign r_end = rlast || (cnt_q == len_q);

`ifdef AXI_MASTER_TIMEOUT_EN
    logic [15:0] wd_q;
    logic        busy, any_hs, to_hit;
    assign busy   = (state != IDLE) && (state != DONE);
    assign any_hs = (awvalid && awready) || w_hs || (bvalid && bready) ||
                    (arvalid && arready) || r_hs;
    assign to_hit = busy && !any_hs && (wd_q == 16'(TIMEOUT_CYCLES - 1));

    // Watchdog: restarted on command accept and on every channel handshake
    always_ff @(posedge aclk) begin
        if (areset)
            wd_q <= '0;
        else if ((state == IDLE) || any_hs || !busy)
            wd_q <= '0;
        else
            wd_q <= wd_q + 16'd1;
    end
`endif

    // Read response merge: first non-OKAY sticks; a premature rlast on an
    // otherwise clean burst is reported as SLVERR
    always_comb begin
        rd_resp_nx = (resp_q == 2'b00) ? rresp : resp_q;
        if (rlast && (cnt_q != len_q) && (rd_resp_nx == 2'b00))
            rd_resp_nx = 2'b10;
    end

    // Next-state and channel handshake outputs, all decoded from state
    always_comb begin
        state_nx   = state;
        cmd_ready  = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        wr_ready   = 1'b0;
        wlast      = 1'b0;
        bready     = 1'b0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        done_valid = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid)
                    state_nx = cmd_write ? WR_ADDR : RD_ADDR;
            end
            WR_ADDR: begin
                awvalid = 1'b1;
                if (awready) state_nx = WR_DATA;
            end
            WR_DATA: begin
                wvalid   = wr_valid;
                wr_ready = wready;
                wlast    = (cnt_q == len_q);
                if (wr_valid && wready && (cnt_q == len_q))
                    state_nx = WR_RESP;
            end
            WR_RESP: begin
                bready = 1'b1;
                if (bvalid) state_nx = DONE;
            end
            RD_ADDR: begin
                arvalid = 1'b1;
                if (arready) state_nx = RD_DATA;
            end
            RD_DATA: begin
                rready = 1'b1;
                if (rvalid && r_end) state_nx = DONE;
            end
            DONE: begin
                done_valid = 1'b1;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
`ifdef AXI_MASTER_TIMEOUT_EN
        if (to_hit) state_nx = DONE;
`endif
    end

    // State, latched command fields, beat counter, response and read data
    always_ff @(posedge aclk) begin
        if (areset) begin
            state    <= IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            id_q     <= '0;
            cnt_q    <= '0;
            resp_q   <= 2'b00;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            state    <= state_nx;
            rd_valid <= 1'b0;
            if ((state == IDLE) && cmd_valid) begin
                addr_q <= cmd_addr;
                len_q  <= cmd_len[LEN_W-1:0];
                id_q   <= cmd_id;
                cnt_q  <= '0;
                resp_q <= 2'b00;
            end
            if (w_hs)
                cnt_q <= cnt_q + 1'b1;
            if ((state == WR_RESP) && bvalid)
                resp_q <= bresp;
            if (r_hs) begin
                rd_data  <= rdata;
                rd_valid <= 1'b1;
                cnt_q    <= cnt_q + 1'b1;
                resp_q   <= rd_resp_nx;
            end
`ifdef AXI_MASTER_TIMEOUT_EN
            if (to_hit)
                resp_q <= 2'b10;
`endif
        end
    end

endmodule

// File: tb/tb_axi_master_generic.sv
// tb_axi_master_generic: directed + randomized transactions against an
// in-bench slave; expected beats and final responses come from AXI rules.
module tb_axi_master_generic;

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 256;
`endif

    logic aclk = 1'b0;
    logic areset;
    logic cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [3:0] cmd_len, cmd_id;
    logic [31:0] wr_data;
    logic [3:0] wr_strb;
    logic wr_valid, wr_ready;
    logic [31:0] rd_data;
    logic rd_valid, done_valid;
    logic [1:0] done_resp;
    logic [3:0] awid, awlen, awcache;
    logic [31:0] awadr;
    logic [2:0] awsize, awprot;
    logic [1:0] awburst, awlock;
    logic awvalid, awready;
    logic [3:0] wid, wstrb;
    logic [31:0] wrdata;
    logic wlast, wvalid, wready;
    logic [3:0] bid;
    logic [1:0] bresp;
    logic bvalid, bready;
    logic [3:0] arid, arlen, arcache;
    logic [31:0] araddr;
    logic [2:0] arsize, arprot;
    logic [1:0] arburst, arlock;
    logic arvalid, arready;
    logic [3:0] rid;
    logic [31:0] rdata;
    logic [1:0] rresp;
    logic rlast, rvalid, rready;

    int tests = 0;
    int fails = 0;

    logic [31:0] rdata_tab[16];
    logic [1:0]  rresp_tab[16];

    axi_master_generic #(.ADDR_W(32), .MAX_LEN(16), .TIMEOUT_CYCLES(TO)) dut (
        .aclk(aclk), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .done_valid(done_valid), .done_resp(done_resp),
        .awid(awid), .awadr(awadr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wrdata(wrdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk_const();
        chk("aw_const", {19'd0, awsize, awburst, awlock, awcache, awprot}, {19'd0, 3'd2, 2'd1, 2'd0, 4'd0, 3'd0});
        chk("ar_const", {19'd0, arsize, arburst, arlock, arcache, arprot}, {19'd0, 3'd2, 2'd1, 2'd0, 4'd0, 3'd0});
    endtask

    // Accept a command; leaves the bench one cycle into the address phase
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [3:0] len, input logic [3:0] id);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_id = id;
        #1;
        chk("cmd_ready_idle", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0; cmd_addr = $urandom; cmd_len = 4'($urandom); cmd_id = 4'($urandom);
    endtask

    // Write burst. fixed: data 0xA0+i, strb F, slave always ready.
    // b_dly < 0: slave never answers (watchdog path). abort_at >= 0: reset after that many beats.
    task automatic write_txn(input logic [31:0] addr, input logic [3:0] len, input logic [3:0] id,
                             input bit fixed, input int aw_dly, input int gap_pct,
                             input int b_dly, input logic [1:0] bresp_v, input int abort_at);
        logic [31:0] d[16];
        logic [3:0]  s[16];
        int b, cyc, n;
        logic hs;
        for (int i = 0; i < 16; i++) begin
            d[i] = fixed ? 32'hA0 + 32'(i) : $urandom;
            s[i] = fixed ? 4'hF : 4'($urandom);
        end
        issue(1'b1, addr, len, id);
        for (int k = 0; k < aw_dly; k++) begin
            awready = 1'b0; #1;
            chk("aw_hold_valid", awvalid, 1);
            chk("aw_hold_addr", awadr, addr);
            chk("aw_hold_len_id", {awlen, awid}, {len, id});
            chk("w_idle", {wvalid, wr_ready}, 0);
            tick();
        end
        awready = 1'b1; #1;
        chk("awvalid", awvalid, 1);
        chk("awadr", awadr, addr);
        chk("awlen_id", {awlen, awid}, {len, id});
        chk_const();
        tick();
        awready = 1'b0;
        b = 0; cyc = 0;
        while (b <= int'(len) && cyc < 400) begin
            if (abort_at >= 0 && b == abort_at) begin
                areset = 1'b1; wr_valid = 1'b1; wready = 1'b1;
                tick();
                chk("rst_wvalid", wvalid, 0);
                chk("rst_cmd_ready", cmd_ready, 1);
                chk("rst_other_valids", {awvalid, wr_ready, bready, arvalid, rready, done_valid, rd_valid}, 0);
                areset = 1'b0; wr_valid = 1'b0; wready = 1'b0;
                for (int k = 0; k < 6; k++) begin
                    tick();
                    chk("rst_no_done", {done_valid, cmd_ready}, 2'b01);
                end
                return;
            end
            wr_valid = fixed ? 1'b1 : ($urandom_range(99) >= gap_pct);
            wready   = fixed ? 1'b1 : ($urandom_range(3) != 0);
            wr_data  = d[b]; wr_strb = s[b];
            #1;
            chk("wvalid_pass", {wvalid, wr_ready}, {wr_valid, wready});
            chk("wlast", wlast, (b == int'(len)));
            if (wr_valid) begin
                chk("wrdata", wrdata, d[b]);
                chk("wstrb_wid", {wstrb, wid}, {s[b], id});
            end
            hs = wr_valid && wready;
            tick();
            if (hs) b++;
            cyc++;
        end
        chk("w_budget", (cyc < 400), 1);
        // Offer extra beats: none may leak onto W after wlast
        wr_valid = 1'b1; wready = 1'b1; wr_data = 32'hDEAD_BEEF;
        if (b_dly < 0) begin
            n = 0;
            while (!done_valid && n < 40) begin
                chk("to_wait_bready", bready, 1);
                tick(); n++;
            end
            chk("to_cycles", n, TO);
            chk("to_resp", done_resp, 2'b10);
            bvalid = 1'b1; bresp = 2'b00;
            tick();
            chk("to_after", {done_valid, bready, cmd_ready}, 3'b001);
            bvalid = 1'b0;
            wr_valid = 1'b0; wready = 1'b0;
            return;
        end
        for (int k = 0; k < b_dly; k++) begin
            bvalid = 1'b0; #1;
            chk("b_wait", {bready, wvalid, done_valid}, 3'b100);
            tick();
        end
        bvalid = 1'b1; bresp = bresp_v; bid = 4'($urandom); #1;
        chk("b_bready", {bready, wvalid}, 2'b10);
        tick();
        bvalid = 1'b0; wr_valid = 1'b0; wready = 1'b0; #1;
        chk("w_done_pulse", {done_valid, cmd_ready, bready}, 3'b100);
        chk("w_done_resp", done_resp, bresp_v);
        tick();
        chk("w_after_done", {done_valid, cmd_ready}, 2'b01);
    endtask

    // Read burst using rdata_tab/rresp_tab; rlast is driven on beat last_at
    // (values > len mean the slave never raises rlast)
    task automatic read_txn(input logic [31:0] addr, input logic [3:0] len, input logic [3:0] id,
                            input int ar_dly, input int last_at);
        int nb, i, cyc;
        logic [1:0] exp;
        logic prev;
        nb  = ((last_at < int'(len)) ? last_at : int'(len)) + 1;
        exp = 2'b00;
        for (int k = 0; k < nb; k++)
            if (exp == 2'b00) exp = rresp_tab[k];
        if (last_at < int'(len) && exp == 2'b00) exp = 2'b10;
        issue(1'b0, addr, len, id);
        for (int k = 0; k < ar_dly; k++) begin
            arready = 1'b0; #1;
            chk("ar_hold", {arvalid, arlen, arid}, {1'b1, len, id});
            chk("ar_hold_addr", araddr, addr);
            tick();
        end
        arready = 1'b1; #1;
        chk("arvalid", {arvalid, arlen, arid, awvalid}, {1'b1, len, id, 1'b0});
        chk("araddr", araddr, addr);
        chk_const();
        tick();
        arready = 1'b0;
        i = 0; cyc = 0; prev = 1'b0;
        while (i < nb && cyc < 400) begin
            rvalid = ($urandom_range(2) != 0);
            rdata = rdata_tab[i]; rresp = rresp_tab[i];
            rlast = (i == last_at); rid = id;
            #1;
            chk("rready", {rready, done_valid}, 2'b10);
            chk("rd_valid", rd_valid, prev);
            if (prev) chk("rd_data", rd_data, rdata_tab[i-1]);
            prev = rvalid;
            tick();
            if (prev) i++;
            cyc++;
        end
        chk("r_budget", (cyc < 400), 1);
        rvalid = 1'b0; rlast = 1'b0; #1;
        chk("r_last_beat", {rd_valid, done_valid, rready, cmd_ready}, 4'b1100);
        chk("r_last_data", rd_data, rdata_tab[nb-1]);
        chk("r_done_resp", done_resp, exp);
        tick();
        chk("r_after_done", {done_valid, rd_valid, cmd_ready}, 3'b001);
    endtask

    task automatic fill_rd(input bit rnd_resp);
        for (int k = 0; k < 16; k++) begin
            rdata_tab[k] = $urandom;
            case ($urandom_range(9))
                0: rresp_tab[k] = rnd_resp ? 2'b10 : 2'b00;
                1: rresp_tab[k] = rnd_resp ? 2'b11 : 2'b00;
                default: rresp_tab[k] = 2'b00;
            endcase
        end
    endtask

    initial begin
        areset = 1'b1;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_id = 0;
        wr_data = 0; wr_strb = 0; wr_valid = 0;
        awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0; arready = 0;
        rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
        repeat (3) tick();
        chk("reset_ready", cmd_ready, 1);
        chk("reset_valids", {awvalid, wvalid, wr_ready, bready, arvalid, rready, rd_valid, done_valid}, 0);
        chk("reset_regs", {done_resp, awlen, awid, arlen, arid}, 0);
        chk("reset_addr", awadr | araddr, 0);
        chk("reset_rd_data", rd_data, 0);
        areset = 1'b0;
        tick();

        // Basic write: four fixed beats, slave always ready
        write_txn(32'h10, 4'd3, 4'd5, 1'b1, 0, 0, 0, 2'b00, -1);
        // Basic read: two beats, rlast on the second
        rdata_tab[0] = 32'h1111_1111; rdata_tab[1] = 32'h2222_2222;
        rresp_tab[0] = 2'b00; rresp_tab[1] = 2'b00;
        read_txn(32'h20, 4'd1, 4'd2, 0, 1);
        // Slow AW, gapped write data
        write_txn(32'h1000, 4'd3, 4'd7, 1'b0, 5, 50, 2, 2'b00, -1);
        // Error response on beat 1 of 3 is sticky; all beats still delivered
        fill_rd(1'b0); rresp_tab[1] = 2'b11;
        read_txn(32'h40, 4'd2, 4'd3, 1, 2);
        // Early rlast on a clean burst -> SLVERR
        fill_rd(1'b0);
        read_txn(32'h80, 4'd5, 4'd9, 0, 2);
        // Max-length read without rlast: ends on beat count
        fill_rd(1'b0);
        read_txn(32'h100, 4'd15, 4'd1, 2, 16);
        // Max-length write with DECERR
        write_txn(32'h200, 4'd15, 4'd14, 1'b0, 1, 30, 3, 2'b11, -1);
        // Single-beat write and read
        write_txn(32'h300, 4'd0, 4'd4, 1'b0, 0, 20, 0, 2'b10, -1);
        fill_rd(1'b0);
        read_txn(32'h304, 4'd0, 4'd4, 0, 0);
        // Reset in the middle of a write after 2 of 4 beats
        write_txn(32'h400, 4'd3, 4'd6, 1'b1, 0, 0, 0, 2'b00, 2);
        // Randomized mix
        for (int t = 0; t < 16; t++) begin
            if ($urandom_range(1) == 1) begin
                write_txn($urandom, 4'($urandom), 4'($urandom), 1'b0, $urandom_range(3),
                          $urandom_range(60), $urandom_range(3), 2'($urandom_range(1) * 2 + $urandom_range(1)), -1);
            end else begin
                fill_rd(1'b1);
                read_txn($urandom, 4'($urandom), 4'($urandom), $urandom_range(3), $urandom_range(17));
            end
        end
`ifdef AXI_MASTER_TIMEOUT_EN
        // Slave never returns a write response
        write_txn(32'h500, 4'd1, 4'd8, 1'b1, 0, 0, -1, 2'b00, -1);
        write_txn(32'h600, 4'd1, 4'd8, 1'b1, 0, 0, 0, 2'b00, -1);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
